// File: rtl/csa_word_seq_if.sv
// Valid/ready operand and result bundle for csa_word_seq.
// CSA_WORD_SEQ_SUB_EN adds the per-operation subtract select 'sub'.
interface csa_word_seq_if #(
  parameter int NBYTES = 4
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   a;
  logic [8*NBYTES-1:0]   b;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   sum;
  logic                  carry;
  logic                  busy;
`ifdef CSA_WORD_SEQ_SUB_EN
  logic                  sub;

  modport master (output in_valid, a, b, sub, out_ready,
                  input  in_ready, out_valid, sum, carry, busy);
  modport slave  (input  in_valid, a, b, sub, out_ready,
                  output in_ready, out_valid, sum, carry, busy);
`else
  modport master (output in_valid, a, b, out_ready,
                  input  in_ready, out_valid, sum, carry, busy);
  modport slave  (input  in_valid, a, b, out_ready,
                  output in_ready, out_valid, sum, carry, busy);
`endif
endinterface

// File: rtl/csa_word_seq.sv
// Byte-serial wide adder: one shared 8-bit carry-select slice, NBYTES cycles per word.
// Optional CSA_WORD_SEQ_SUB_EN adds A-B via inverted B bytes and carry-in of 1.
module csa_word_seq #(
  parameter int NBYTES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  csa_word_seq_if.slave bus
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Low nibble ripples with cin; high nibble is precomputed for both carries and selected.
  function automatic logic [8:0] csel_add8(input logic [7:0] x, input logic [7:0] y,
                                           input logic ci);
    logic [4:0] lo;
    logic [4:0] hi0;
    logic [4:0] hi1;
    logic [4:0] hi;
    lo  = {1'b0, x[3:0]} + {1'b0, y[3:0]} + {4'b0000, ci};
    hi0 = {1'b0, x[7:4]} + {1'b0, y[7:4]};
    hi1 = {1'b0, x[7:4]} + {1'b0, y[7:4]} + 5'd1;
    hi  = lo[4] ? hi1 : hi0;
    return {hi, lo[3:0]};
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_reg_q, carry_reg_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic            busy_q, busy_d;
  logic            sub_q, sub_d;
  logic [7:0]      a_byte_s;
  logic [7:0]      b_byte_s;
  logic [8:0]      slice_s;

  // Byte slice for the current index.
  always_comb begin
    a_byte_s = a_q[{idx_q, 3'b000} +: 8];
    b_byte_s = b_q[{idx_q, 3'b000} +: 8] ^ {8{sub_q}};
    slice_s  = csel_add8(a_byte_s, b_byte_s, carry_reg_q);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_reg_d = carry_reg_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    sub_d       = sub_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = ADD;
          a_d     = bus.a;
          b_d     = bus.b;
          sum_d   = '0;
          carry_d = 1'b0;
          idx_d   = '0;
`ifdef CSA_WORD_SEQ_SUB_EN
          sub_d       = bus.sub;
          carry_reg_d = bus.sub;
`else
          sub_d       = 1'b0;
          carry_reg_d = 1'b0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        sum_d[{idx_q, 3'b000} +: 8] = slice_s[7:0];
        carry_reg_d = slice_s[8];
        idx_d       = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          carry_d = slice_s[8];
          state_d = DONE;
        end else begin
          state_d = ADD;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_reg_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_reg_q <= carry_reg_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      sub_q       <= sub_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_csa_word_seq.sv
// Randomized and directed bench for csa_word_seq with a queue-based arithmetic reference.
module tb_csa_word_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk;
  logic rst_n;
  csa_word_seq_if #(.NBYTES(NB)) ifc ();

  csa_word_seq #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_acc = 0;
  int n_done = 0;
  int n_flush = 0;
  bit seen = 1'b0;
  bit rand_rdy = 1'b0;
  logic [W:0] exp_q[$];
  int acc_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s);
    if (s) return {(x >= y), x - y};
    else   return {1'b0, x} + {1'b0, y};
  endfunction

  // Reference scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    logic s;
    if (!rst_n) begin
      n_flush += exp_q.size();
      exp_q.delete();
      acc_q.delete();
      seen = 1'b0;
    end else begin
      chk("in_ready_vs_busy", {63'd0, ifc.in_ready}, {63'd0, ~ifc.busy});
      if (ifc.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc - acc_q[0]), 64'(NB));
            seen = 1'b1;
          end
          chk("model_sum", {32'd0, ifc.sum}, {32'd0, exp_q[0][W-1:0]});
          chk("model_carry", {63'd0, ifc.carry}, {63'd0, exp_q[0][W]});
          if (ifc.out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            n_done++;
            seen = 1'b0;
          end
        end
      end
      if (ifc.in_valid && ifc.in_ready) begin
`ifdef CSA_WORD_SEQ_SUB_EN
        s = ifc.sub;
`else
        s = 1'b0;
`endif
        exp_q.push_back(model(ifc.a, ifc.b, s));
        acc_q.push_back(cyc + 1);
        n_acc++;
      end
    end
  end

  // Random consumer backpressure during regression.
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      ifc.out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    bit ok;
    bit done;
    done = 1'b0;
    ifc.in_valid = 1'b1;
    ifc.a = x;
    ifc.b = y;
`ifdef CSA_WORD_SEQ_SUB_EN
    ifc.sub = s;
`endif
    for (int t = 0; t < 300 && !done; t++) begin
      ok = ifc.in_valid && ifc.in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1'b1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
    ifc.in_valid = 1'b0;
    ifc.a = W'($urandom());
    ifc.b = W'($urandom());
  endtask

  task automatic result(input string name, input logic [W-1:0] es, input logic ec);
    bit got;
    got = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      if (ifc.out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) chk({name, "_timeout"}, 64'd0, 64'd1);
    chk({name, "_sum"}, {32'd0, ifc.sum}, {32'd0, es});
    chk({name, "_carry"}, {63'd0, ifc.carry}, {63'd0, ec});
    if (ifc.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit got;
    rst_n = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.a = '0;
    ifc.b = '0;
    ifc.out_ready = 1'b1;
`ifdef CSA_WORD_SEQ_SUB_EN
    ifc.sub = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, ifc.busy}, 64'd0);
    chk("rst_sum", {32'd0, ifc.sum}, 64'd0);
    chk("rst_carry", {63'd0, ifc.carry}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Carry ripple with exact latency.
    send(32'h000000FF, 32'h00000001, 1'b0);
    for (int i = 1; i <= NB; i++) begin
      @(posedge clk);
      #1;
      chk("ripple_out_valid_timing", {63'd0, ifc.out_valid}, (i == NB) ? 64'd1 : 64'd0);
    end
    chk("ripple_sum", {32'd0, ifc.sum}, 64'h00000100);
    chk("ripple_carry", {63'd0, ifc.carry}, 64'd0);
    @(posedge clk);
    #1;
    chk("ripple_busy_low", {63'd0, ifc.busy}, 64'd0);

    send(32'hFFFFFFFF, 32'h00000001, 1'b0);
    result("wrap1", 32'h00000000, 1'b1);
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    result("wrap2", 32'hFFFFFFFE, 1'b1);

    // Backpressure with a new operand pair held pending.
    ifc.out_ready = 1'b0;
    send(32'h12345678, 32'h11111111, 1'b0);
    ifc.in_valid = 1'b1;
    ifc.a = 32'd1;
    ifc.b = 32'd1;
    got = 1'b0;
    for (int t = 0; t < 50 && !got; t++) begin
      if (ifc.out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("bp_out_valid", {63'd0, ifc.out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_sum", {32'd0, ifc.sum}, 64'h23456789);
      chk("bp_hold_carry", {63'd0, ifc.carry}, 64'd0);
      chk("bp_in_ready", {63'd0, ifc.in_ready}, 64'd0);
      chk("bp_hold_valid", {63'd0, ifc.out_valid}, 64'd1);
      @(posedge clk);
      #1;
    end
    ifc.out_ready = 1'b1;
    send(32'd1, 32'd1, 1'b0);
    result("bp_second", 32'h00000002, 1'b0);

    // Asynchronous reset in the middle of an addition.
    send(32'hAAAAAAAA, 32'h55555555, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {63'd0, ifc.out_valid}, 64'd0);
    chk("mid_rst_sum", {32'd0, ifc.sum}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, ifc.in_ready}, 64'd1);
    chk("mid_rst_busy", {63'd0, ifc.busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(32'd3, 32'd4, 1'b0);
    result("post_rst", 32'd7, 1'b0);

`ifdef CSA_WORD_SEQ_SUB_EN
    send(32'd5, 32'd7, 1'b1);
    result("sub_borrow", 32'hFFFFFFFE, 1'b0);
    send(32'd7, 32'd5, 1'b1);
    result("sub_noborrow", 32'h00000002, 1'b1);
`endif

    // Random regression with toggling out_ready.
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
`ifdef CSA_WORD_SEQ_SUB_EN
      send(W'($urandom()), W'($urandom()), 1'($urandom_range(0, 1)));
`else
      send(W'($urandom()), W'($urandom()), 1'b0);
`endif
    end
    for (int t = 0; t < 2000 && exp_q.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2;
    ifc.out_ready = 1'b1;
    chk("drain_queue", 64'(exp_q.size()), 64'd0);
    chk("handshake_count", 64'(n_done), 64'(n_acc - n_flush));
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
